// File: rtl/mmcm_drp_seq.sv
// rtl/mmcm_drp_seq.sv - MMCM reconfiguration sequencer driving the DRP port
// Holds a small buffer of (addr, keep-mask, data) entries loaded from the
// register layer. On start it holds the MMCM in reset, performs a
// read-modify-write per entry, releases reset and waits for LOCKED.
module mmcm_drp_seq #(
  parameter int pDEPTH        = 8,
  parameter int pDRDY_TIMEOUT = 255,
  parameter int pLOCK_TIMEOUT = 65535
) (
  input  logic                     clk_usb,
  input  logic                     reset_n,
  input  logic                     cmd_wr,
  input  logic [6:0]               cmd_addr,
  input  logic [15:0]              cmd_mask,
  input  logic [15:0]              cmd_data,
  input  logic                     cmd_clear,
  output logic [$clog2(pDEPTH):0]  cmd_count,
  output logic                     cmd_overflow,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [1:0]               err_code,
  output logic [6:0]               drp_addr,
  output logic                     drp_den,
  output logic                     drp_dwe,
  output logic [15:0]              drp_din,
  input  logic [15:0]              drp_dout,
  input  logic                     drp_drdy,
  output logic                     mmcm_rst,
  input  logic                     mmcm_locked
);

  localparam int CW = $clog2(pDEPTH) + 1;
  localparam int AW = $clog2(pDEPTH);
  localparam int DW = $clog2(pDRDY_TIMEOUT + 1);
  localparam int LW = $clog2(pLOCK_TIMEOUT + 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(pDEPTH);
  localparam logic [DW-1:0] DRDY_TO_C = DW'(pDRDY_TIMEOUT);
  localparam logic [LW-1:0] LOCK_TO_C = LW'(pLOCK_TIMEOUT);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RST,
    S_RD,
    S_RD_WAIT,
    S_WR,
    S_WR_WAIT,
    S_REL,
    S_WAIT_LOCK,
    S_FIN
  } state_t;

  state_t          state_q, state_d;
  logic [38:0]     mem_q [pDEPTH];
  logic [38:0]     mem_d [pDEPTH];
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   idx_q, idx_d;
  logic            ovf_q, ovf_d;
  logic            err_q, err_d;
  logic [1:0]      code_q, code_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  logic [LW-1:0]   lcnt_q, lcnt_d;
  logic            rdy_q, rdy_d;
  logic [15:0]     rdata_q, rdata_d;
  logic [15:0]     new_q, new_d;
  logic            lock_meta_q, lock_sync_q;

  logic [38:0]     entry;
  logic [6:0]      ent_addr;
  logic [15:0]     ent_mask;
  logic [15:0]     ent_data;
  logic [CW-1:0]   idx_inc;

  assign entry    = mem_q[idx_q[AW-1:0]];
  assign ent_addr = entry[38:32];
  assign ent_mask = entry[31:16];
  assign ent_data = entry[15:0];
  assign idx_inc  = idx_q + 1'b1;

  assign cmd_count    = cnt_q;
  assign cmd_overflow = ovf_q;
  assign error        = err_q;
  assign err_code     = code_q;

  // Next-state, buffer update and DRP/MMCM outputs decoded from the current state
  always_comb begin
    state_d  = state_q;
    mem_d    = mem_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    code_d   = code_q;
    dcnt_d   = dcnt_q;
    lcnt_d   = lcnt_q;
    rdy_d    = rdy_q;
    rdata_d  = rdata_q;
    new_d    = new_q;
    busy     = 1'b0;
    done     = 1'b0;
    drp_den  = 1'b0;
    drp_dwe  = 1'b0;
    drp_addr = 7'd0;
    drp_din  = 16'd0;
    mmcm_rst = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Clear beats everything else; a start in the same cycle as a push
        // takes priority so the entry count cannot change under the sequence.
        if (cmd_clear) begin
          cnt_d = '0;
          ovf_d = 1'b0;
        end else if (start && (cnt_q != '0)) begin
          err_d   = 1'b0;
          code_d  = 2'd0;
          idx_d   = '0;
          state_d = S_RST;
        end else if (cmd_wr) begin
          if (cnt_q < DEPTH_C) begin
            mem_d[cnt_q[AW-1:0]] = {cmd_addr, cmd_mask, cmd_data};
            cnt_d = cnt_q + 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end
      end

      S_RST: begin
        busy     = 1'b1;
        mmcm_rst = 1'b1;
        state_d  = S_RD;
      end

      S_RD: begin
        busy     = 1'b1;
        mmcm_rst = 1'b1;
        drp_den  = 1'b1;
        drp_addr = ent_addr;
        dcnt_d   = DW'(1);
        // drdy may answer in the den cycle itself; keep it for the wait state
        rdy_d    = drp_drdy;
        if (drp_drdy) rdata_d = drp_dout;
        state_d  = S_RD_WAIT;
      end

      S_RD_WAIT: begin
        busy     = 1'b1;
        mmcm_rst = 1'b1;
        drp_addr = ent_addr;
        if (rdy_q) begin
          new_d   = (rdata_q & ent_mask) | (ent_data & ~ent_mask);
          state_d = S_WR;
        end else if (dcnt_q >= DRDY_TO_C) begin
          err_d   = 1'b1;
          code_d  = 2'd1;
          state_d = S_REL;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
          if (drp_drdy) begin
            rdy_d   = 1'b1;
            rdata_d = drp_dout;
          end
        end
      end

      S_WR: begin
        busy     = 1'b1;
        mmcm_rst = 1'b1;
        drp_den  = 1'b1;
        drp_dwe  = 1'b1;
        drp_addr = ent_addr;
        drp_din  = new_q;
        dcnt_d   = DW'(1);
        rdy_d    = drp_drdy;
        state_d  = S_WR_WAIT;
      end

      S_WR_WAIT: begin
        busy     = 1'b1;
        mmcm_rst = 1'b1;
        drp_addr = ent_addr;
        if (rdy_q) begin
          idx_d   = idx_inc;
          state_d = (idx_inc == cnt_q) ? S_REL : S_RD;
        end else if (dcnt_q >= DRDY_TO_C) begin
          err_d   = 1'b1;
          code_d  = 2'd1;
          state_d = S_REL;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
          if (drp_drdy) rdy_d = 1'b1;
        end
      end

      S_REL: begin
        busy    = 1'b1;
        lcnt_d  = LOCK_TO_C;
        state_d = S_WAIT_LOCK;
      end

      S_WAIT_LOCK: begin
        busy = 1'b1;
        if (lock_sync_q) begin
          state_d = S_FIN;
        end else if (lcnt_q == '0) begin
          err_d = 1'b1;
          // an earlier drdy timeout is the more useful diagnosis; keep it
          if (code_q == 2'd0) code_d = 2'd2;
          state_d = S_FIN;
        end else begin
          lcnt_d = lcnt_q - 1'b1;
        end
      end

      S_FIN: begin
        done    = 1'b1;
        cnt_d   = '0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state, buffer and counters
  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      for (int i = 0; i < pDEPTH; i++) mem_q[i] <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 2'd0;
      dcnt_q  <= '0;
      lcnt_q  <= '0;
      rdy_q   <= 1'b0;
      rdata_q <= 16'd0;
      new_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      mem_q   <= mem_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      code_q  <= code_d;
      dcnt_q  <= dcnt_d;
      lcnt_q  <= lcnt_d;
      rdy_q   <= rdy_d;
      rdata_q <= rdata_d;
      new_q   <= new_d;
    end
  end

  // Two-flop synchroniser for the asynchronous LOCKED input
  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) begin
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
    end else begin
      lock_meta_q <= mmcm_locked;
      lock_sync_q <= lock_meta_q;
    end
  end

endmodule

// File: tb/tb_mmcm_drp_seq.sv
// tb/tb_mmcm_drp_seq.sv - scoreboard bench for the MMCM DRP sequencer
module tb_mmcm_drp_seq;

  logic        clk_usb = 1'b0;
  logic        reset_n;
  logic        cmd_wr;
  logic [6:0]  cmd_addr;
  logic [15:0] cmd_mask;
  logic [15:0] cmd_data;
  logic        cmd_clear;
  logic [3:0]  cmd_count;
  logic        cmd_overflow;
  logic        start;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  err_code;
  logic [6:0]  drp_addr;
  logic        drp_den;
  logic        drp_dwe;
  logic [15:0] drp_din;
  logic [15:0] drp_dout;
  logic        drp_drdy;
  logic        mmcm_rst;
  logic        mmcm_locked;

  mmcm_drp_seq #(
    .pDEPTH(8),
    .pDRDY_TIMEOUT(255),
    .pLOCK_TIMEOUT(100)
  ) dut (
    .clk_usb(clk_usb),
    .reset_n(reset_n),
    .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr),
    .cmd_mask(cmd_mask),
    .cmd_data(cmd_data),
    .cmd_clear(cmd_clear),
    .cmd_count(cmd_count),
    .cmd_overflow(cmd_overflow),
    .start(start),
    .busy(busy),
    .done(done),
    .error(error),
    .err_code(err_code),
    .drp_addr(drp_addr),
    .drp_den(drp_den),
    .drp_dwe(drp_dwe),
    .drp_din(drp_din),
    .drp_dout(drp_dout),
    .drp_drdy(drp_drdy),
    .mmcm_rst(mmcm_rst),
    .mmcm_locked(mmcm_locked)
  );

  always #5 clk_usb = ~clk_usb;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int den_cyc = 0;

  logic [22:0] exp_wr[$];
  logic [2:0]  exp_done[$];

  logic [15:0] drp_mem [128];
  bit          drp_respond;
  int          drp_delay;
  bit          stray_req;
  bit          lock_en;
  int          lock_delay;

  always @(posedge clk_usb) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  // Monitor: pops expected writes and done results whenever the DUT presents them
  always @(negedge clk_usb) begin
    logic [22:0] ew;
    logic [2:0]  ed;
    if (reset_n) begin
      if (drp_den || drp_dwe) begin
        check("dwe_only_with_den", drp_den, 1);
        check("rst_held_during_drp", mmcm_rst, 1);
      end
      if (drp_den) begin
        den_cyc = cyc;
        if (drp_dwe) wr_cnt++;
        else rd_cnt++;
      end
      if (drp_den && drp_dwe) begin
        if (exp_wr.size() == 0) fail_now("unexpected_write");
        else begin
          ew = exp_wr.pop_front();
          check("wr_addr", drp_addr, ew[22:16]);
          check("wr_data", drp_din, ew[15:0]);
        end
      end
      if (done) begin
        done_cnt++;
        check("busy_low_at_done", busy, 0);
        if (exp_done.size() == 0) fail_now("unexpected_done");
        else begin
          ed = exp_done.pop_front();
          check("done_error", error, ed[2]);
          check("done_err_code", err_code, ed[1:0]);
        end
      end
    end
  end

  // DRP slave model: answers den after drp_delay cycles, writes update drp_mem
  initial begin
    int pend;
    logic [6:0] p_addr;
    logic p_we;
    pend = 0; p_addr = 0; p_we = 0;
    drp_drdy = 1'b0;
    drp_dout = 16'h0;
    forever begin
      @(negedge clk_usb);
      drp_drdy = 1'b0;
      if (!reset_n) pend = 0;
      else begin
        if (stray_req) begin
          drp_drdy = 1'b1;
          drp_dout = 16'hDEAD;
          stray_req = 1'b0;
        end
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            drp_drdy = 1'b1;
            drp_dout = p_we ? 16'h0 : drp_mem[p_addr];
          end
        end
        if (drp_den && drp_respond) begin
          pend = drp_delay;
          p_addr = drp_addr;
          p_we = drp_dwe;
          if (drp_dwe) drp_mem[drp_addr] = drp_din;
        end
      end
    end
  end

  // MMCM lock model: LOCKED rises lock_delay cycles after reset release
  initial begin
    int lk;
    lk = 0;
    mmcm_locked = 1'b0;
    forever begin
      @(negedge clk_usb);
      if (mmcm_rst) begin
        mmcm_locked = 1'b0;
        lk = 0;
      end else if (lock_en) begin
        if (lk < lock_delay) lk++;
        else mmcm_locked = 1'b1;
      end else begin
        mmcm_locked = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic init_mem;
    for (int i = 0; i < 128; i++) drp_mem[i] = 16'h0;
    drp_mem[8] = 16'h1234;
    drp_mem[9] = 16'h5678;
  endtask

  task automatic push(input logic [6:0] a, input logic [15:0] m, input logic [15:0] d);
    @(negedge clk_usb);
    cmd_wr = 1'b1; cmd_addr = a; cmd_mask = m; cmd_data = d;
    @(negedge clk_usb);
    cmd_wr = 1'b0;
  endtask

  task automatic pulse_start;
    @(negedge clk_usb); start = 1'b1;
    @(negedge clk_usb); start = 1'b0;
  endtask

  task automatic pulse_clear;
    @(negedge clk_usb); cmd_clear = 1'b1;
    @(negedge clk_usb); cmd_clear = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int c0;
    int n;
    c0 = done_cnt;
    n = 0;
    while (done_cnt == c0 && n < budget) begin
      @(negedge clk_usb); #1;
      n++;
    end
    if (done_cnt == c0) fail_now(name);
  endtask

  task automatic wait_rst_low(input string name, input int budget);
    int n;
    n = 0;
    while (mmcm_rst && n < budget) begin
      @(negedge clk_usb); #1;
      n++;
    end
    if (mmcm_rst) fail_now(name);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_mmcm_rst"}, mmcm_rst, 0);
    check({tag, "_den"}, drp_den, 0);
    check({tag, "_dwe"}, drp_dwe, 0);
    check({tag, "_addr"}, drp_addr, 0);
    check({tag, "_din"}, drp_din, 0);
    check({tag, "_count"}, cmd_count, 0);
  endtask

  initial begin
    int rd0, wr0, d0, t0, diff, n;
    reset_n = 1'b0;
    cmd_wr = 0; cmd_addr = 0; cmd_mask = 0; cmd_data = 0; cmd_clear = 0; start = 0;
    drp_respond = 1; drp_delay = 2; stray_req = 0; lock_en = 1; lock_delay = 50;
    init_mem();

    // reset state
    repeat (3) @(negedge clk_usb);
    #1;
    check_idle_outputs("reset");
    check("reset_overflow", cmd_overflow, 0);
    check("reset_error", error, 0);
    check("reset_err_code", err_code, 0);
    @(negedge clk_usb) reset_n = 1'b1;

    // happy path
    push(7'h08, 16'h1000, 16'h0041);
    push(7'h09, 16'hFC00, 16'h0080);
    check("happy_count", cmd_count, 2);
    exp_wr.push_back({7'h08, 16'h1041});
    exp_wr.push_back({7'h09, 16'h5480});
    exp_done.push_back(3'b000);
    rd0 = rd_cnt; d0 = done_cnt;
    pulse_start();
    check("happy_busy", busy, 1);
    check("happy_rst", mmcm_rst, 1);
    wait_done("happy_done_timeout", 1000);
    @(negedge clk_usb); #1;
    check("happy_count_after", cmd_count, 0);
    check("happy_reads", rd_cnt - rd0, 2);
    check("happy_single_done", done_cnt - d0, 1);

    // overflow, clear, clear-with-write, start on empty buffer
    for (int i = 0; i < 9; i++) push(7'(i), 16'h0, 16'(i));
    check("ovf_count", cmd_count, 8);
    check("ovf_flag", cmd_overflow, 1);
    pulse_clear();
    check("clear_count", cmd_count, 0);
    check("clear_overflow", cmd_overflow, 0);
    push(7'h01, 16'h0, 16'h1);
    check("one_push_count", cmd_count, 1);
    @(negedge clk_usb); cmd_clear = 1'b1; cmd_wr = 1'b1;
    @(negedge clk_usb); cmd_clear = 1'b0; cmd_wr = 1'b0;
    check("clear_wins_count", cmd_count, 0);
    d0 = done_cnt;
    pulse_start();
    n = 0;
    repeat (10) begin
      @(negedge clk_usb); #1;
      if (busy) n++;
    end
    check("empty_start_no_busy", n, 0);
    check("empty_start_no_done", done_cnt - d0, 0);

    // drdy timeout
    init_mem();
    drp_respond = 0;
    push(7'h08, 16'h0000, 16'hABCD);
    exp_done.push_back({1'b1, 2'd1});
    rd0 = rd_cnt; wr0 = wr_cnt;
    pulse_start();
    wait_rst_low("drdy_to_rst_release", 400);
    diff = cyc - den_cyc;
    check("drdy_to_window", (diff >= 250 && diff <= 262), 1);
    wait_done("drdy_to_done_timeout", 300);
    check("drdy_to_one_den", rd_cnt - rd0, 1);
    check("drdy_to_no_write", wr_cnt - wr0, 0);
    drp_respond = 1;

    // lock timeout, then a clean run clears the error
    init_mem();
    lock_en = 0;
    push(7'h08, 16'hFF00, 16'h0055);
    exp_wr.push_back({7'h08, 16'h1255});
    exp_done.push_back({1'b1, 2'd2});
    pulse_start();
    wait_rst_low("lock_to_rst_release", 200);
    t0 = cyc;
    wait_done("lock_to_done_timeout", 300);
    diff = cyc - t0;
    check("lock_to_window", (diff >= 100 && diff <= 110), 1);
    lock_en = 1;
    push(7'h08, 16'h00FF, 16'hA000);
    exp_wr.push_back({7'h08, 16'hA055});
    exp_done.push_back(3'b000);
    pulse_start();
    check("start_clears_error", error, 0);
    check("start_clears_code", err_code, 0);
    wait_done("clean_done_timeout", 500);

    // interference while busy
    init_mem();
    push(7'h08, 16'h1000, 16'h0041);
    push(7'h09, 16'hFC00, 16'h0080);
    exp_wr.push_back({7'h08, 16'h1041});
    exp_wr.push_back({7'h09, 16'h5480});
    exp_done.push_back(3'b000);
    d0 = done_cnt;
    pulse_start();
    repeat (3) @(negedge clk_usb);
    @(negedge clk_usb); cmd_wr = 1'b1; cmd_addr = 7'h10;
    @(negedge clk_usb); cmd_wr = 1'b0; cmd_clear = 1'b1;
    @(negedge clk_usb); cmd_clear = 1'b0; start = 1'b1;
    @(negedge clk_usb); start = 1'b0;
    #1;
    check("busy_count_kept", cmd_count, 2);
    check("busy_still", busy, 1);
    wait_rst_low("intf_rst_release", 200);
    repeat (5) @(negedge clk_usb);
    stray_req = 1'b1;
    repeat (3) @(negedge clk_usb);
    #1;
    check("stray_drdy_still_busy", busy, 1);
    wait_done("intf_done_timeout", 300);
    repeat (20) @(negedge clk_usb);
    #1;
    check("intf_single_done", done_cnt - d0, 1);
    check("intf_count_after", cmd_count, 0);

    // async reset in RD_WAIT
    init_mem();
    drp_delay = 30;
    push(7'h08, 16'h0000, 16'h0001);
    rd0 = rd_cnt;
    pulse_start();
    n = 0;
    while (rd_cnt == rd0 && n < 20) begin
      @(negedge clk_usb); #1;
      n++;
    end
    check("arst_saw_read_den", rd_cnt - rd0, 1);
    repeat (3) @(negedge clk_usb);
    #3;
    reset_n = 1'b0;
    #1;
    check_idle_outputs("arst");
    @(negedge clk_usb); reset_n = 1'b1;
    drp_delay = 2;
    init_mem();
    push(7'h09, 16'hFC00, 16'h0080);
    exp_wr.push_back({7'h09, 16'h5480});
    exp_done.push_back(3'b000);
    pulse_start();
    wait_done("post_reset_done_timeout", 500);
    @(negedge clk_usb); #1;
    check("post_reset_count", cmd_count, 0);

    repeat (5) @(negedge clk_usb);
    check("writes_all_seen", exp_wr.size(), 0);
    check("dones_all_seen", exp_done.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
